// File: rtl/move_sequencer_if.sv
// Player-input and game-logic signal bundle for move_sequencer.
// slave is the sequencer side; master is whoever drives requests and observes results.
interface move_sequencer_if;
  logic       new_game;
  logic       drop_req;
  logic [2:0] drop_col;
  logic       logic_result;
  logic       board_clr;
  logic       go;
  logic [2:0] address;
  logic [5:0] onoff_write;
  logic [5:0] player_write;
  logic       cur_player;
  logic       drop_ack;
  logic       drop_err;
  logic       game_over;
  logic       winner;
  logic       draw;

  modport master (
    output new_game, drop_req, drop_col, logic_result,
    input  board_clr, go, address, onoff_write, player_write,
    input  cur_player, drop_ack, drop_err, game_over, winner, draw
  );

  modport slave (
    input  new_game, drop_req, drop_col, logic_result,
    output board_clr, go, address, onoff_write, player_write,
    output cur_player, drop_ack, drop_err, game_over, winner, draw
  );
endinterface

// File: rtl/move_sequencer.sv
// Connect Four turn controller: owns the 7x6 board, issues column writes, tracks the outcome.
// Define DRAW_DETECT_EN to end the game as a draw once all 42 cells are filled.
module move_sequencer (
  input logic             clk,
  input logic             reset,
  move_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StInit, StIdle, StCheck, StWrite, StEval, StOver} state_e;

  state_e     state_q;
  logic [5:0] occ_q [7];
  logic [5:0] own_q [7];
  logic [5:0] move_cnt_q;
  logic [2:0] col_q;
  logic       cur_player_q;
  logic       go_q;
  logic [2:0] address_q;
  logic [5:0] onoff_q;
  logic [5:0] player_q;
  logic       drop_ack_q;
  logic       drop_err_q;
  logic       game_over_q;
  logic       winner_q;
  logic       draw_q;

  logic       col_ok;
  logic [5:0] occ_sel;
  logic [5:0] own_sel;
  logic [2:0] height;
  logic [5:0] occ_next;
  logic [5:0] own_next;

  always_comb begin
    col_ok  = (col_q <= 3'd6);
    occ_sel = col_ok ? occ_q[col_q] : 6'd0;
    own_sel = col_ok ? own_q[col_q] : 6'd0;
    height  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      height = height + {2'b00, occ_sel[i]};
    end
    occ_next = {occ_sel[4:0], 1'b1};
    own_next = own_sel | ({5'b00000, cur_player_q} << height);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      move_cnt_q   <= 6'd0;
      col_q        <= 3'd0;
      cur_player_q <= 1'b0;
      go_q         <= 1'b0;
      address_q    <= 3'd0;
      onoff_q      <= 6'd0;
      player_q     <= 6'd0;
      drop_ack_q   <= 1'b0;
      drop_err_q   <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      draw_q       <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        occ_q[i] <= 6'd0;
        own_q[i] <= 6'd0;
      end
    end else begin
      go_q       <= 1'b0;
      address_q  <= 3'd0;
      onoff_q    <= 6'd0;
      player_q   <= 6'd0;
      drop_ack_q <= 1'b0;
      drop_err_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          move_cnt_q   <= 6'd0;
          cur_player_q <= 1'b0;
          for (int i = 0; i < 7; i++) begin
            occ_q[i] <= 6'd0;
            own_q[i] <= 6'd0;
          end
          state_q <= StIdle;
        end
        StIdle: begin
          if (bus.new_game) begin
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
            state_q     <= StInit;
          end else if (bus.drop_req) begin
            col_q   <= bus.drop_col;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (!col_ok || height == 3'd6) begin
            drop_err_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            // Outputs are registered, so the write strobe is launched here to appear in WRITE.
            go_q          <= 1'b1;
            address_q     <= col_q;
            onoff_q       <= occ_next;
            player_q      <= own_next;
            occ_q[col_q]  <= occ_next;
            own_q[col_q]  <= own_next;
            move_cnt_q    <= move_cnt_q + 6'd1;
            state_q       <= StWrite;
          end
        end
        StWrite: begin
          drop_ack_q <= 1'b1;
          state_q    <= StEval;
        end
        StEval: begin
          if (bus.logic_result) begin
            winner_q    <= cur_player_q;
            game_over_q <= 1'b1;
            state_q     <= StOver;
`ifdef DRAW_DETECT_EN
          end else if (move_cnt_q == 6'd42) begin
            draw_q      <= 1'b1;
            game_over_q <= 1'b1;
            state_q     <= StOver;
`endif
          end else begin
            cur_player_q <= ~cur_player_q;
            state_q      <= StIdle;
          end
        end
        StOver: begin
          if (bus.new_game) begin
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
            state_q     <= StInit;
          end else if (bus.drop_req) begin
            drop_err_q <= 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // INIT is the clear cycle; held low while reset itself is asserted.
  assign bus.board_clr    = (state_q == StInit) && !reset;
  assign bus.go           = go_q;
  assign bus.address      = address_q;
  assign bus.onoff_write  = onoff_q;
  assign bus.player_write = player_q;
  assign bus.cur_player   = cur_player_q;
  assign bus.drop_ack     = drop_ack_q;
  assign bus.drop_err     = drop_err_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;
  assign bus.draw         = draw_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: table of single drops plus hand-written corner sequences.
module tb_move_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  move_sequencer_if bus ();

  move_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int failed = 0;
  int overlap_n = 0;
  int idle_bus_n = 0;

  typedef struct {
    logic [2:0] col;
    logic       lr;
    logic       acc;
    logic [5:0] onoff;
    logic [5:0] pw;
    logic       cur;
    logic       over;
    logic       win;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic watch();
    if ((int'(bus.go) + int'(bus.drop_ack) + int'(bus.drop_err) + int'(bus.board_clr)) > 1)
      overlap_n++;
    if (!bus.go && (bus.address != 3'd0 || bus.onoff_write != 6'd0 || bus.player_write != 6'd0))
      idle_bus_n++;
  endtask

  // Called at a negedge; returns the offset (in cycles) at which each pulse was first seen.
  task automatic do_drop(input logic [2:0] col, input logic lr,
                         output int go_at, output int go_n, output int ack_at, output int err_at,
                         output logic [2:0] a, output logic [5:0] ow, output logic [5:0] pw);
    go_at = -1; go_n = 0; ack_at = -1; err_at = -1; a = 3'd0; ow = 6'd0; pw = 6'd0;
    bus.drop_col = col;
    bus.drop_req = 1'b1;
    bus.logic_result = lr;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.drop_req = 1'b0;
      watch();
      if (bus.go) begin
        go_n++;
        if (go_at < 0) begin
          go_at = i; a = bus.address; ow = bus.onoff_write; pw = bus.player_write;
        end
      end
      if (bus.drop_ack && ack_at < 0) ack_at = i;
      if (bus.drop_err && err_at < 0) err_at = i;
    end
    bus.logic_result = 1'b0;
  endtask

  int go_at, go_n, ack_at, err_at, n_acc, seen;
  logic [2:0] a;
  logic [5:0] ow, pw;

  initial begin
    //            col   lr    acc   onoff      player     cur   over  win
    vecs[0]  = '{3'd3, 1'b0, 1'b1, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd3, 1'b0, 1'b1, 6'b000011, 6'b000010, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd7, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd0, 1'b0, 1'b1, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd0, 1'b0, 1'b1, 6'b000011, 6'b000010, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd0, 1'b0, 1'b1, 6'b000111, 6'b000010, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 1'b0, 1'b1, 6'b001111, 6'b001010, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd0, 1'b0, 1'b1, 6'b011111, 6'b001010, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 1'b0, 1'b1, 6'b111111, 6'b101010, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd3, 1'b0, 1'b1, 6'b000111, 6'b000010, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd5, 1'b1, 1'b1, 6'b000001, 6'b000001, 1'b1, 1'b1, 1'b1};

    bus.new_game = 1'b0;
    bus.drop_req = 1'b0;
    bus.drop_col = 3'd0;
    bus.logic_result = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({bus.board_clr, bus.go, bus.address, bus.onoff_write,
                               bus.player_write, bus.cur_player, bus.drop_ack, bus.drop_err,
                               bus.game_over, bus.winner, bus.draw}), 0);
    reset = 1'b0;
    #1 check("init_board_clr", int'(bus.board_clr), 1);
    @(negedge clk);
    watch();
    check("idle_board_clr", int'(bus.board_clr), 0);
    check("idle_cur_player", int'(bus.cur_player), 0);

    // Table of single drops
    for (int v = 0; v < 12; v++) begin
      do_drop(vecs[v].col, vecs[v].lr, go_at, go_n, ack_at, err_at, a, ow, pw);
      if (vecs[v].acc) begin
        check($sformatf("v%0d_go_at", v), go_at, 2);
        check($sformatf("v%0d_ack_at", v), ack_at, 3);
        check($sformatf("v%0d_err_at", v), err_at, -1);
        check($sformatf("v%0d_address", v), int'(a), int'(vecs[v].col));
        check($sformatf("v%0d_onoff", v), int'(ow), int'(vecs[v].onoff));
        check($sformatf("v%0d_player", v), int'(pw), int'(vecs[v].pw));
      end else begin
        check($sformatf("v%0d_err_at", v), err_at, 2);
        check($sformatf("v%0d_ack_at", v), ack_at, -1);
      end
      check($sformatf("v%0d_go_count", v), go_n, vecs[v].acc ? 1 : 0);
      check($sformatf("v%0d_cur_player", v), int'(bus.cur_player), int'(vecs[v].cur));
      check($sformatf("v%0d_game_over", v), int'(bus.game_over), int'(vecs[v].over));
      check($sformatf("v%0d_winner", v), int'(bus.winner), int'(vecs[v].win));
    end

    // OVER: drops are rejected one cycle later, no write
    do_drop(3'd1, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    check("over_err_at", err_at, 1);
    check("over_go_count", go_n, 0);
    check("over_ack_at", ack_at, -1);
    check("over_game_over", int'(bus.game_over), 1);

    // new_game from OVER
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    watch();
    check("ng_board_clr", int'(bus.board_clr), 1);
    check("ng_game_over", int'(bus.game_over), 0);
    check("ng_winner", int'(bus.winner), 0);
    @(negedge clk);
    watch();
    check("ng_clr_done", int'(bus.board_clr), 0);
    check("ng_cur_player", int'(bus.cur_player), 0);

    do_drop(3'd3, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    check("ng_empty_onoff", int'(ow), 1);
    check("ng_empty_player", int'(pw), 0);

    // new_game and drop_req together in IDLE: request dropped silently
    bus.new_game = 1'b1;
    bus.drop_req = 1'b1;
    bus.drop_col = 3'd4;
    seen = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.new_game = 1'b0;
      bus.drop_req = 1'b0;
      watch();
      if (bus.go || bus.drop_ack || bus.drop_err) seen++;
      if (i == 1) check("ngdrop_board_clr", int'(bus.board_clr), 1);
    end
    check("ngdrop_no_pulses", seen, 0);

    // Reset in the WRITE cycle aborts the move
    do_drop(3'd0, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    bus.drop_col = 3'd2;
    bus.drop_req = 1'b1;
    @(negedge clk);
    bus.drop_req = 1'b0;
    @(negedge clk);
    check("rw_go", int'(bus.go), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rw_no_ack", int'(bus.drop_ack), 0);
    reset = 1'b0;
    #1 check("rw_board_clr", int'(bus.board_clr), 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      watch();
      if (bus.go || bus.drop_ack || bus.drop_err) seen++;
    end
    check("rw_no_pulses", seen, 0);
    do_drop(3'd0, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    check("rw_empty_onoff", int'(ow), 1);
    check("rw_empty_player", int'(pw), 0);
    check("rw_cur_player", int'(bus.cur_player), 1);

    // Fill all 42 cells with no win reported
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    @(negedge clk);
    n_acc = 0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        do_drop(3'(c), 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
        if (go_at == 2 && ack_at == 3) n_acc++;
      end
    end
    check("full_accepted", n_acc, 42);
`ifdef DRAW_DETECT_EN
    check("full_draw", int'(bus.draw), 1);
    check("full_game_over", int'(bus.game_over), 1);
    do_drop(3'd6, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    check("full_43_err_at", err_at, 1);
`else
    check("full_draw", int'(bus.draw), 0);
    check("full_game_over", int'(bus.game_over), 0);
    do_drop(3'd6, 1'b0, go_at, go_n, ack_at, err_at, a, ow, pw);
    check("full_43_err_at", err_at, 2);
`endif
    check("full_43_go_count", go_n, 0);

    check("pulse_overlap", overlap_n, 0);
    check("idle_bus_zero", idle_bus_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Turn-level controller for the Connect Four datapath: accepts column-drop requests from the input side, holds the authoritative 7×6 board, and sequences single-column writes into the game-logic unit. It also clears that unit, alternates players, rejects illegal moves, and latches the win/draw outcome. It sits between the player-input front end and the game-logic unit; the VGA/display path reads its board and status outputs.

## Interface
Parameters: none (board is fixed at 7 columns × 6 rows).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- new_game  in  1  level; restart game without global reset (honoured in IDLE or OVER only)
- drop_req  in  1  one-cycle request to drop a piece, honoured in IDLE only
- drop_col  in  3  target column 0–6, sampled with drop_req
- logic_result  in  1  win indication from logic unit, sampled in EVAL
- board_clr  out  1  clear strobe to logic unit reset input
- go  out  1  one-cycle column write strobe to logic unit
- address  out  3  column being written, valid while go=1
- onoff_write  out  6  new occupancy column (bit0 = bottom row), valid while go=1
- player_write  out  6  new owner column (1 = player 1), valid while go=1
- cur_player  out  1  player whose turn it is
- drop_ack  out  1  one-cycle pulse: move accepted and evaluated
- drop_err  out  1  one-cycle pulse: move rejected
- game_over  out  1  level, set on win or draw
- winner  out  1  player who made the winning move; valid when game_over=1 and draw=0
- draw  out  1  level, board full with no win (see Configuration)

## Operation
- Internal state: seven 6-bit occupancy columns, seven 6-bit owner columns, and a 6-bit move counter (0–42).
- Column height h is the popcount of the occupancy column. Occupancy is always contiguous from bit0.
- States: INIT, IDLE, CHECK, WRITE, EVAL, OVER.
- INIT: board_clr=1 for exactly one cycle; all columns, the counter and cur_player (=0) are cleared. Next state is IDLE.
- IDLE: on drop_req, latch drop_col and go to CHECK. drop_req in any other state is ignored with no pulse, except in OVER.
- CHECK: the move is illegal if col>6 or h==6.
  - Illegal: pulse drop_err and return to IDLE; board and cur_player unchanged.
  - Legal: go to WRITE.
- WRITE: drive go=1 with address=col.
  - onoff_write = (occ<<1)|1.
  - player_write = own | (cur_player<<h).
  - Commit both columns internally and increment the counter.
- EVAL: sample logic_result and pulse drop_ack.
  - If logic_result=1: winner=cur_player, game_over=1, go to OVER.
  - Else, if the draw condition holds: draw=1, game_over=1, go to OVER.
  - Else: toggle cur_player and return to IDLE.
- OVER: every drop_req produces a drop_err pulse one cycle later; the board is frozen.
- new_game in IDLE or OVER goes to INIT and clears game_over, winner and draw. new_game is ignored in CHECK, WRITE and EVAL.

## Timing
- Reset values: state=INIT; board_clr=0, go=0, address=0, onoff_write=0, player_write=0, cur_player=0, drop_ack=0, drop_err=0, game_over=0, winner=0, draw=0.
- The first cycle after reset deasserts is INIT, so board_clr=1 in that cycle.
- Accepted move: drop_req at cycle N, CHECK at N+1, go at N+2, drop_ack at N+3. The next drop_req is honoured from N+4.
- Rejected move: drop_err at N+2 (after CHECK). In OVER, drop_err follows drop_req at N+1.
- address, onoff_write and player_write are 0 whenever go=0.
- go, drop_ack, drop_err and board_clr are single-cycle pulses; no two are ever high in the same cycle.
- logic_result must be valid in the cycle after go (it is sampled in EVAL).
- Reset mid-move, in any state: the next state is INIT and no go, drop_ack or drop_err is issued afterwards for the aborted move.
- reset has priority over new_game. new_game in the same cycle as drop_req in IDLE: new_game wins and the request is dropped silently.

## Configuration
- DRAW_DETECT_EN defined: when the counter reaches 42 in EVAL with logic_result=0, set draw=1 and game_over=1, then go to OVER.
- DRAW_DETECT_EN undefined: draw is tied to 0. A full board stays in IDLE, and every drop is rejected through the h==6 rule.

## Test plan
- Reset, then idle: board_clr high for one cycle, all other outputs 0, cur_player=0.
- Drop into column 3 at N: go at N+2 with address=3, onoff_write=000001, player_write=000000; drop_ack at N+3; cur_player becomes 1. A second drop into column 3 gives onoff_write=000011 and player_write=000010.
- Six drops into column 0, then a seventh: drop_err at N+2, no go, cur_player unchanged. drop_col=7 is also rejected.
- Drive logic_result=1 in EVAL of player 1's move: game_over=1, winner=1. Further drop_req gives drop_err and no go. new_game gives board_clr and clears game_over.
- With DRAW_DETECT_EN defined and logic_result held at 0, fill all 42 cells: draw=1 and game_over=1 after the 42nd drop_ack. Without the macro: draw=0 and the 43rd drop is rejected.
- Assert reset in the WRITE cycle: no drop_ack follows, board_clr pulses, and the board reads empty.
